// File: rtl/mmc_bus_arbiter_pkg.sv
// Shared types and widths for the two-requester matrix-multiply bus arbiter.
// Holds the FSM state encoding and the pending-request record.
package mmc_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } slot_t;

endpackage

// File: rtl/mmc_req_slot.sv
// One requester port: single pending slot, illegal-pulse error and sticky overflow.
// o_slot/o_valid include the request arriving this cycle so IDLE can grant it at once.
module mmc_req_slot
  import mmc_bus_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_wen,
  input  logic              i_ren,
  input  logic              i_clr,
  output slot_t             o_slot,
  output logic              o_valid,
  output logic              o_ill_err,
  output logic              o_ovf
);

  logic  r_full;
  logic  r_ill_err;
  logic  r_ovf;
  slot_t r_slot;

  logic  w_pulse;
  logic  w_ill;
  logic  w_load;
  slot_t w_in;

  always_comb begin
    w_in       = '0;
    w_in.addr  = i_addr;
    w_in.wdata = i_wdata;
    w_in.sel   = i_sel;
    w_in.we    = i_wen;
  end

  assign w_pulse = i_wen ^ i_ren;
  assign w_ill   = i_wen & i_ren;
  // Clearing in RESP frees the slot on the same edge a new pulse may load it.
  assign w_load  = w_pulse & (~r_full | i_clr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full    <= 1'b0;
      r_ill_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ill_err <= w_ill;
      if (w_load)
        r_full <= 1'b1;
      else if (i_clr)
        r_full <= 1'b0;
      if (w_pulse && r_full && !i_clr)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load)
      r_slot <= w_in;
  end

  assign o_valid   = r_full | w_load;
  assign o_slot    = r_full ? r_slot : w_in;
  assign o_ill_err = r_ill_err;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/mmc_bus_arbiter.sv
// Round-robin arbiter sharing one matrix-multiply bus slave between two requesters,
// with a registered slave strobe, response capture and a wait-state timeout.
module mmc_bus_arbiter
  import mmc_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_wen_i,
  input  logic              m0_ren_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_wen_i,
  input  logic              m1_ren_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_wen_o,
  output logic              s_ren_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic              ovf_o
);

  localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_grant;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;
  logic [SEL_W-1:0]  r_s_sel;
  logic              r_s_wen;
  logic              r_s_ren;

  slot_t w_slot0, w_slot1, w_gslot;
  logic  w_v0, w_v1, w_pick;
  logic  w_ill0, w_ill1, w_ovf0, w_ovf1;
  logic  w_resp, w_clr0, w_clr1;

  assign w_resp = (r_state == ST_RESP);
  assign w_clr0 = w_resp & ~r_grant;
  assign w_clr1 = w_resp &  r_grant;

  mmc_req_slot u_slot0 (
    .i_clk(system1000), .i_rst(system1000_rst),
    .i_addr(m0_addr_i), .i_wdata(m0_wdata_i), .i_sel(m0_sel_i),
    .i_wen(m0_wen_i), .i_ren(m0_ren_i), .i_clr(w_clr0),
    .o_slot(w_slot0), .o_valid(w_v0), .o_ill_err(w_ill0), .o_ovf(w_ovf0)
  );

  mmc_req_slot u_slot1 (
    .i_clk(system1000), .i_rst(system1000_rst),
    .i_addr(m1_addr_i), .i_wdata(m1_wdata_i), .i_sel(m1_sel_i),
    .i_wen(m1_wen_i), .i_ren(m1_ren_i), .i_clr(w_clr1),
    .o_slot(w_slot1), .o_valid(w_v1), .o_ill_err(w_ill1), .o_ovf(w_ovf1)
  );

  // Contention goes to the port that did not win last time.
  assign w_pick  = (w_v0 && w_v1) ? ~r_last : w_v1;
  assign w_gslot = w_pick ? w_slot1 : w_slot0;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
      r_rdata   <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_sel   <= '0;
      r_s_wen   <= 1'b0;
      r_s_ren   <= 1'b0;
    end else begin
      r_s_wen <= 1'b0;
      r_s_ren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_v0 || w_v1) begin
            r_grant   <= w_pick;
            r_last    <= w_pick;
            r_s_addr  <= w_gslot.addr;
            r_s_wdata <= w_gslot.wdata;
            r_s_sel   <= w_gslot.sel;
            r_s_wen   <= w_gslot.we;
            r_s_ren   <= ~w_gslot.we;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
          if (s_ack_i || s_err_i) begin
            r_rsp_err <= s_err_i;
            r_rdata   <= s_rdata_i;
            r_state   <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s_ack_i || s_err_i) begin
            r_rsp_err <= s_err_i;
            r_rdata   <= s_rdata_i;
            r_state   <= ST_RESP;
          end else if (r_cnt == LP_TMO_LAST) begin
            r_rsp_err <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack_o   = w_clr0 & ~r_rsp_err;
  assign m1_ack_o   = w_clr1 & ~r_rsp_err;
  assign m0_err_o   = (w_clr0 & r_rsp_err) | w_ill0;
  assign m1_err_o   = (w_clr1 & r_rsp_err) | w_ill1;
  assign m0_rdata_o = m0_ack_o ? r_rdata : '0;
  assign m1_rdata_o = m1_ack_o ? r_rdata : '0;

  assign s_addr_o  = r_s_addr;
  assign s_wdata_o = r_s_wdata;
  assign s_sel_o   = r_s_sel;
  assign s_wen_o   = r_s_wen;
  assign s_ren_o   = r_s_ren;
  assign ovf_o     = w_ovf0 | w_ovf1;

endmodule

// File: tb/tb_mmc_bus_arbiter.sv
// Directed bench for mmc_bus_arbiter with TIMEOUT=4; the bench plays the slave.
module tb_mmc_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_wen, m0_ren, m1_wen, m1_ren;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        s_wen, s_ren, s_ack, s_err, ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmc_bus_arbiter #(.TIMEOUT(4)) dut (
    .system1000(clk), .system1000_rst(rst),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_sel_i(m0_sel),
    .m0_wen_i(m0_wen), .m0_ren_i(m0_ren),
    .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_sel_i(m1_sel),
    .m1_wen_i(m1_wen), .m1_ren_i(m1_ren),
    .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_sel_o(s_sel),
    .s_wen_o(s_wen), .s_ren_o(s_ren),
    .s_rdata_i(s_rdata), .s_ack_i(s_ack), .s_err_i(s_err),
    .ovf_o(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wen, input logic ren,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_wen = wen; m0_ren = ren; m0_addr = addr; m0_wdata = wdata; m0_sel = 4'hF;
    end else begin
      m1_wen = wen; m1_ren = ren; m1_addr = addr; m1_wdata = wdata; m1_sel = 4'h3;
    end
  endtask

  task automatic clr_req();
    m0_wen = 1'b0; m0_ren = 1'b0; m1_wen = 1'b0; m1_ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_addr = '0; m0_wdata = '0; m0_sel = '0;
    m1_addr = '0; m1_wdata = '0; m1_sel = '0;
    clr_req();
    s_rdata = '0; s_ack = 1'b0; s_err = 1'b0;
    tick(); tick();

    check("rst_s_wen", {31'd0, s_wen}, 32'd0);
    check("rst_s_ren", {31'd0, s_ren}, 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    check("rst_m1_err", {31'd0, m1_err}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // Write from port 0, slave acks one cycle after the strobe.
    set_req(0, 1'b1, 1'b0, 32'h4000_0010, 32'h0000_000A);
    tick(); clr_req();
    check("wr_s_wen", {31'd0, s_wen}, 32'd1);
    check("wr_s_ren", {31'd0, s_ren}, 32'd0);
    check("wr_s_addr", s_addr, 32'h4000_0010);
    check("wr_s_wdata", s_wdata, 32'h0000_000A);
    check("wr_s_sel", {28'd0, s_sel}, 32'hF);
    tick();
    check("wr_s_wen_drop", {31'd0, s_wen}, 32'd0);
    check("wr_s_addr_hold", s_addr, 32'h4000_0010);
    check("wr_ack_early", {31'd0, m0_ack}, 32'd0);
    s_ack = 1'b1;
    tick(); s_ack = 1'b0;
    check("wr_m0_ack", {31'd0, m0_ack}, 32'd1);
    check("wr_m0_err", {31'd0, m0_err}, 32'd0);
    check("wr_m1_ack", {31'd0, m1_ack}, 32'd0);
    tick();
    check("wr_m0_ack_once", {31'd0, m0_ack}, 32'd0);

    // Minimum-latency read from port 1.
    set_req(1, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    tick(); clr_req();
    check("rd_s_ren", {31'd0, s_ren}, 32'd1);
    check("rd_s_addr", s_addr, 32'h0000_0100);
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    tick(); s_ack = 1'b0; s_rdata = '0;
    check("rd_m1_ack", {31'd0, m1_ack}, 32'd1);
    check("rd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("rd_m0_rdata", m0_rdata, 32'd0);
    tick();
    check("rd_m1_rdata_idle", m1_rdata, 32'd0);

    // Simultaneous reads: port 0 then port 1, and again port 0 first.
    for (int it = 0; it < 2; it++) begin
      set_req(0, 1'b0, 1'b1, 32'h0000_00A0, 32'h0);
      set_req(1, 1'b0, 1'b1, 32'h0000_00B0, 32'h0);
      tick(); clr_req();
      check("rr_first_addr", s_addr, 32'h0000_00A0);
      check("rr_first_ren", {31'd0, s_ren}, 32'd1);
      s_ack = 1'b1; s_rdata = 32'h11 + it;
      tick(); s_ack = 1'b0;
      check("rr_m0_ack", {31'd0, m0_ack}, 32'd1);
      check("rr_m0_rdata", m0_rdata, 32'h11 + it);
      check("rr_m1_ack_quiet", {31'd0, m1_ack}, 32'd0);
      check("rr_m1_rdata_zero", m1_rdata, 32'd0);
      tick();
      check("rr_gap_ren", {31'd0, s_ren}, 32'd0);
      tick();
      check("rr_second_addr", s_addr, 32'h0000_00B0);
      check("rr_second_ren", {31'd0, s_ren}, 32'd1);
      s_ack = 1'b1; s_rdata = 32'h22 + it;
      tick(); s_ack = 1'b0; s_rdata = '0;
      check("rr_m1_ack", {31'd0, m1_ack}, 32'd1);
      check("rr_m1_rdata", m1_rdata, 32'h22 + it);
      check("rr_m0_ack_quiet", {31'd0, m0_ack}, 32'd0);
      tick();
    end

    // Timeout: slave never answers port 1.
    s_rdata = 32'hBAD0_BAD0;
    set_req(1, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
    tick(); clr_req();
    check("to_s_ren", {31'd0, s_ren}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait_err", {31'd0, m1_err}, 32'd0);
    end
    tick();
    check("to_m1_err", {31'd0, m1_err}, 32'd1);
    check("to_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("to_m1_rdata", m1_rdata, 32'd0);
    tick();
    s_rdata = '0;
    check("to_m1_err_once", {31'd0, m1_err}, 32'd0);
    set_req(0, 1'b0, 1'b1, 32'h0000_0210, 32'h0);
    tick(); clr_req();
    check("to_idle_ren", {31'd0, s_ren}, 32'd1);
    check("to_idle_addr", s_addr, 32'h0000_0210);
    s_ack = 1'b1; s_rdata = 32'h5A5A_0001;
    tick(); s_ack = 1'b0; s_rdata = '0;
    check("to_idle_ack", {31'd0, m0_ack}, 32'd1);
    tick();

    // Illegal pulse with both wen and ren.
    set_req(0, 1'b1, 1'b1, 32'h0000_0500, 32'h55);
    tick(); clr_req();
    check("ill_m0_err", {31'd0, m0_err}, 32'd1);
    check("ill_m0_ack", {31'd0, m0_ack}, 32'd0);
    check("ill_s_wen", {31'd0, s_wen}, 32'd0);
    check("ill_s_ren", {31'd0, s_ren}, 32'd0);
    tick();
    check("ill_err_once", {31'd0, m0_err}, 32'd0);
    check("ill_no_strobe", {31'd0, s_wen | s_ren}, 32'd0);
    check("ill_ovf", {31'd0, ovf}, 32'd0);

    // Overflow: second pulse while the first is still pending.
    set_req(0, 1'b1, 1'b0, 32'h0000_0300, 32'h33);
    tick(); clr_req();
    check("ovf_s_addr", s_addr, 32'h0000_0300);
    check("ovf_pre", {31'd0, ovf}, 32'd0);
    set_req(0, 1'b0, 1'b1, 32'h0000_0304, 32'h0);
    tick(); clr_req();
    check("ovf_set", {31'd0, ovf}, 32'd1);
    s_ack = 1'b1;
    tick(); s_ack = 1'b0;
    check("ovf_m0_ack", {31'd0, m0_ack}, 32'd1);
    tick(); tick();
    check("ovf_no_second", {31'd0, s_wen | s_ren}, 32'd0);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset during WAIT, late slave ack afterwards.
    set_req(1, 1'b0, 1'b1, 32'h0000_0600, 32'h0);
    tick(); clr_req();
    tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("mrst_s_addr", s_addr, 32'd0);
    check("mrst_ovf", {31'd0, ovf}, 32'd0);
    check("mrst_m1_err", {31'd0, m1_err}, 32'd0);
    tick();
    s_ack = 1'b1; s_rdata = 32'h77;
    tick(); s_ack = 1'b0; s_rdata = '0;
    check("mrst_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("mrst_m1_err_late", {31'd0, m1_err}, 32'd0);
    check("mrst_m1_rdata", m1_rdata, 32'd0);
    check("mrst_s_ren", {31'd0, s_ren}, 32'd0);
    tick();
    set_req(0, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
    tick(); clr_req();
    check("mrst_next_ren", {31'd0, s_ren}, 32'd1);
    check("mrst_next_addr", s_addr, 32'h0000_0400);
    s_ack = 1'b1; s_rdata = 32'h0000_4444;
    tick(); s_ack = 1'b0; s_rdata = '0;
    check("mrst_next_ack", {31'd0, m0_ack}, 32'd1);
    check("mrst_next_rdata", m0_rdata, 32'h0000_4444);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
